// File: rtl/adc083000_sif_pkg.sv
// Shared constants and FSM state type for the ADC083000 serial control master.
package adc083000_sif_pkg;

  localparam logic [11:0] SIF_HEADER  = 12'h001;
  localparam int          SIF_FRAME_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } sif_state_e;

endpackage

// File: rtl/adc083000_ctrl_sif_if.sv
// Command bus, status and 3-wire serial pins of the ADC083000 control master.
interface adc083000_ctrl_sif_if #(
  parameter int NUM_CS = 2
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_addr;
  logic [15:0]       cmd_data;
  logic              cmd_cs;
  logic              busy;
  logic              done;
  logic              sif_sclk;
  logic              sif_sdata;
  logic [NUM_CS-1:0] sif_scs_n;

  // Software side: issues commands, observes status and pins.
  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_cs,
    input  cmd_ready, busy, done, sif_sclk, sif_sdata, sif_scs_n
  );

  // Block side: accepts commands and drives the serial pins.
  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_cs,
    output cmd_ready, busy, done, sif_sclk, sif_sdata, sif_scs_n
  );

endinterface

// File: rtl/adc083000_sif_tick.sv
// SCLK half-period divider: one-cycle tick every CLK_DIV cycles, held at
// phase zero while clr is asserted so every frame starts on a clean period.
module adc083000_sif_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic ctrl_reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == LAST);

  // Count up, wrap on tick, park at zero while cleared.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  // Divider counter register.
  always_ff @(posedge sys_clk or posedge ctrl_reset) begin
    if (ctrl_reset) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc083000_ctrl_sif.sv
// ADC083000 3-wire configuration master: takes one register write per
// handshake and serialises {header, addr, data} MSB first to one board.
module adc083000_ctrl_sif
  import adc083000_sif_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int NUM_CS     = 2
) (
  input logic                 sys_clk,
  input logic                 ctrl_reset,
  adc083000_ctrl_sif_if.slave bus
);

  localparam int            GW       = $clog2(GAP_CYCLES) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  sif_state_e             state_q, state_d;
  logic [SIF_FRAME_W-1:0] sr_q, sr_d;
  logic [4:0]             bit_q, bit_d;
  logic                   phase_q, phase_d;   // 0: SCLK low half, 1: high half
  logic                   cs_q, cs_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   tick;
  logic                   framing;

  adc083000_sif_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .sys_clk    (sys_clk),
    .ctrl_reset (ctrl_reset),
    .clr        (state_q == IDLE),
    .tick       (tick)
  );

  // Next-state: latch on handshake, shift on falling half-period boundary.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    cs_d    = cs_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        state_d = SHIFT;
        sr_d    = {SIF_HEADER, bus.cmd_addr, bus.cmd_data};
        bit_d   = 5'd31;
        phase_d = 1'b0;
        cs_d    = bus.cmd_cs;
      end
      SHIFT: if (tick) begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          // Last bit stays in sr_q[MSB] so HOLD keeps bit 0 on the line.
          if (bit_q == 5'd0) begin
            state_d = HOLD;
          end else begin
            bit_d = bit_q - 5'd1;
            sr_d  = {sr_q[SIF_FRAME_W-2:0], 1'b0};
          end
        end
      end
      HOLD: if (tick) begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      cs_q    <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      cs_q    <= cs_d;
      gap_q   <= gap_d;
    end
  end

  assign framing = (state_q == SHIFT) || (state_q == HOLD);

  // Outputs decoded from registered state so reset forces them at once.
  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == GAP) && (gap_q == GAP_LAST);
    bus.sif_sclk  = (state_q == SHIFT) && phase_q;
    bus.sif_sdata = framing && sr_q[SIF_FRAME_W-1];
    bus.sif_scs_n = '1;
    // A select outside 0..NUM_CS-1 matches nothing, so all lines stay high.
    for (int i = 0; i < NUM_CS; i++)
      bus.sif_scs_n[i] = !(framing && (int'(cs_q) == i));
  end

endmodule

// File: tb/tb_adc083000_ctrl_sif.sv
// Bench for adc083000_ctrl_sif: DUT0 at CLK_DIV=2, DUT1 at CLK_DIV=1, both
// GAP_CYCLES=4, checked against frame/timing rules computed in the bench.
module tb_adc083000_ctrl_sif;

  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc083000_ctrl_sif_if #(.NUM_CS(2)) i0 ();
  adc083000_ctrl_sif_if #(.NUM_CS(2)) i1 ();

  adc083000_ctrl_sif #(.CLK_DIV(2), .GAP_CYCLES(GAP), .NUM_CS(2)) u0 (
    .sys_clk(clk), .ctrl_reset(rst), .bus(i0.slave));
  adc083000_ctrl_sif #(.CLK_DIV(1), .GAP_CYCLES(GAP), .NUM_CS(2)) u1 (
    .sys_clk(clk), .ctrl_reset(rst), .bus(i1.slave));

  logic       o_sclk[2], o_sdata[2], o_busy[2], o_done[2], o_ready[2];
  logic [1:0] o_scs[2];
  assign o_sclk[0]  = i0.sif_sclk;   assign o_sclk[1]  = i1.sif_sclk;
  assign o_sdata[0] = i0.sif_sdata;  assign o_sdata[1] = i1.sif_sdata;
  assign o_busy[0]  = i0.busy;       assign o_busy[1]  = i1.busy;
  assign o_done[0]  = i0.done;       assign o_done[1]  = i1.done;
  assign o_ready[0] = i0.cmd_ready;  assign o_ready[1] = i1.cmd_ready;
  assign o_scs[0]   = i0.sif_scs_n;  assign o_scs[1]   = i1.sif_scs_n;

  int tests = 0;
  int fails = 0;

  function automatic int cdk(input int k);
    return (k == 1) ? 1 : 2;
  endfunction
  function automatic int busy_exp(input int k);
    return 64 * cdk(k) + cdk(k) + GAP;
  endfunction

  // Pin monitor: what a board would see, sampled on the falling sys_clk edge.
  logic [31:0] cap[2]    = '{0, 0};
  logic        psclk[2]  = '{0, 0};
  int nb[2]       = '{0, 0};
  int bcnt[2]     = '{0, 0};
  int dcnt[2]     = '{0, 0};
  int dat[2]      = '{0, 0};
  int noedge[2]   = '{0, 0};
  int multi[2]    = '{0, 0};
  int low0[2]     = '{0, 0};
  int low1[2]     = '{0, 0};
  int badsp[2]    = '{0, 0};
  int cyc[2]      = '{0, 0};
  int lastrise[2] = '{-1, -1};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cyc[k] <= cyc[k] + 1;
      if (o_sclk[k] && !psclk[k]) begin
        cap[k] <= {cap[k][30:0], o_sdata[k]};
        nb[k]  <= nb[k] + 1;
        if (&o_scs[k]) noedge[k] <= noedge[k] + 1;
        if (lastrise[k] >= 0 && (cyc[k] - lastrise[k]) != 2 * cdk(k))
          badsp[k] <= badsp[k] + 1;
        lastrise[k] <= cyc[k];
      end else if (!o_busy[k]) begin
        lastrise[k] <= -1;
      end
      psclk[k] <= o_sclk[k];
      if (o_busy[k]) begin
        bcnt[k] <= bcnt[k] + 1;
        if (!o_scs[k][0]) low0[k] <= low0[k] + 1;
        if (!o_scs[k][1]) low1[k] <= low1[k] + 1;
      end
      if (o_done[k]) begin
        dcnt[k] <= dcnt[k] + 1;
        dat[k]  <= bcnt[k] + 1;
      end
      if (o_scs[k] == 2'b00) multi[k] <= multi[k] + 1;
    end
  end

  int b_nb, b_bcnt, b_dcnt, b_noedge, b_multi, b_low0, b_low1, b_badsp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic snap(input int k);
    b_nb = nb[k];  b_bcnt = bcnt[k];  b_dcnt = dcnt[k];  b_noedge = noedge[k];
    b_multi = multi[k];  b_low0 = low0[k];  b_low1 = low1[k];  b_badsp = badsp[k];
  endtask

  task automatic drive(input int k, input logic v, input logic [3:0] a,
                       input logic [15:0] d, input logic c);
    if (k == 0) begin
      i0.cmd_valid = v; i0.cmd_addr = a; i0.cmd_data = d; i0.cmd_cs = c;
    end else begin
      i1.cmd_valid = v; i1.cmd_addr = a; i1.cmd_data = d; i1.cmd_cs = c;
    end
  endtask

  task automatic send(input int k, input logic [3:0] a, input logic [15:0] d, input logic c);
    @(negedge clk);
    chk("ready_before_cmd", 32'(o_ready[k]), 32'd1);
    drive(k, 1'b1, a, d, c);
    @(posedge clk);
    #1 drive(k, 1'b0, a, d, c);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy[k] && n < budget);
    if (o_busy[k]) chk("busy_timeout", 32'(n), 32'(budget + 1));
    #1;
  endtask

  task automatic check_frame(input int k, input logic [31:0] ef, input logic [1:0] escs);
    int fc = 65 * cdk(k);
    chk("frame",        cap[k], ef);
    chk("nbits",        32'(nb[k] - b_nb), 32'd32);
    chk("busy_len",     32'(bcnt[k] - b_bcnt), 32'(busy_exp(k)));
    chk("done_cnt",     32'(dcnt[k] - b_dcnt), 32'd1);
    chk("done_on_last", 32'(dat[k] - b_bcnt), 32'(busy_exp(k)));
    chk("cs0_low_cyc",  32'(low0[k] - b_low0), escs[0] ? 32'd0 : 32'(fc));
    chk("cs1_low_cyc",  32'(low1[k] - b_low1), escs[1] ? 32'd0 : 32'(fc));
    chk("sclk_no_cs",   32'(noedge[k] - b_noedge), 32'd0);
    chk("multi_cs",     32'(multi[k] - b_multi), 32'd0);
    chk("sclk_period",  32'(badsp[k] - b_badsp), 32'd0);
  endtask

  task automatic run_cmd(input int k, input logic [3:0] a, input logic [15:0] d,
                         input logic c, input logic [31:0] ef, input logic [1:0] escs);
    snap(k);
    send(k, a, d, c);
    wait_idle(k, 2000);
    check_frame(k, ef, escs);
  endtask

  typedef struct {
    int          k;
    logic [3:0]  a;
    logic [15:0] d;
    logic        c;
    logic [31:0] ef;
    logic [1:0]  escs;
  } vec_t;

  vec_t vt[5];

  initial begin
    int n, rise, fall, rc, stage;
    logic prev;
    logic [31:0] capa;
    logic [3:0]  ra;
    logic [15:0] rd;
    logic        rcs;
    int          rk;

    vt[0] = '{0, 4'h1, 16'hB2FF, 1'b0, 32'h0011B2FF, 2'b10};
    vt[1] = '{0, 4'hF, 16'h0000, 1'b1, 32'h001F0000, 2'b01};
    vt[2] = '{0, 4'h5, 16'hA5A5, 1'b0, 32'h0015A5A5, 2'b10};
    vt[3] = '{1, 4'h1, 16'hB2FF, 1'b0, 32'h0011B2FF, 2'b10};
    vt[4] = '{1, 4'h0, 16'hFFFF, 1'b1, 32'h0010FFFF, 2'b01};

    drive(0, 1'b0, 4'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 4'h0, 16'h0, 1'b0);

    // Reset values: {ready, busy, done, sclk, sdata, scs_n}
    repeat (2) @(negedge clk);
    chk("reset_vals0", {26'd0, o_ready[0], o_busy[0], o_done[0], o_sclk[0], o_sdata[0], o_scs[0]}, 32'b1000011);
    chk("reset_vals1", {26'd0, o_ready[1], o_busy[1], o_done[1], o_sclk[1], o_sdata[1], o_scs[1]}, 32'b1000011);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_cmd(vt[i].k, vt[i].a, vt[i].d, vt[i].c, vt[i].ef, vt[i].escs);

    // Random commands against the frame/timing rules.
    for (int i = 0; i < 8; i++) begin
      rk  = int'($urandom_range(0, 1));
      ra  = 4'($urandom);
      rd  = 16'($urandom);
      rcs = 1'($urandom);
      run_cmd(rk, ra, rd, rcs, {12'h001, ra, rd}, rcs ? 2'b01 : 2'b10);
    end

    // Back-to-back with cmd_valid held: second frame follows after the gap.
    snap(0);
    @(negedge clk);
    drive(0, 1'b1, 4'h3, 16'h1234, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b1, 4'hC, 16'h5678, 1'b0);
    n = 0; rise = 0; fall = 0; rc = 0; stage = 0; prev = 1'b0; capa = '0;
    while (stage != 2 && n < 1000) begin
      @(negedge clk);
      n++;
      if (stage == 0 && o_scs[0][0] && !prev) begin
        rise = n; stage = 1; capa = cap[0];
      end else if (stage == 1) begin
        if (o_ready[0]) rc++;
        if (!o_scs[0][0]) begin fall = n; stage = 2; end
      end
      prev = o_scs[0][0];
    end
    drive(0, 1'b0, 4'h0, 16'h0, 1'b0);
    chk("b2b_reached", 32'(stage), 32'd2);
    wait_idle(0, 2000);
    chk("b2b_frame_a",   capa, 32'h00131234);
    chk("b2b_frame_b",   cap[0], 32'h001C5678);
    chk("b2b_gap",       32'(fall - rise), 32'(GAP + 1));
    chk("b2b_ready_cyc", 32'(rc), 32'd1);
    chk("b2b_nbits",     32'(nb[0] - b_nb), 32'd64);
    chk("b2b_done_cnt",  32'(dcnt[0] - b_dcnt), 32'd2);

    // cmd_valid pulsed mid-frame is ignored.
    snap(0);
    send(0, 4'h7, 16'hBEEF, 1'b0);
    repeat (20) @(negedge clk);
    drive(0, 1'b1, 4'h2, 16'h0F0F, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 16'h0, 1'b0);
    wait_idle(0, 2000);
    repeat (10) @(negedge clk);
    #1;
    chk("ign_frame",    cap[0], 32'h0017BEEF);
    chk("ign_nbits",    32'(nb[0] - b_nb), 32'd32);
    chk("ign_done_cnt", 32'(dcnt[0] - b_dcnt), 32'd1);
    chk("ign_cs1_low",  32'(low1[0] - b_low1), 32'd0);
    chk("ign_busy_after", 32'(o_busy[0]), 32'd0);

    // Asynchronous reset while bit 17 is on the wire.
    snap(0);
    send(0, 4'h9, 16'h4321, 1'b0);
    n = 0;
    while ((nb[0] - b_nb) < 15 && n < 1000) begin
      @(negedge clk);
      #1 n++;
    end
    chk("rst_reach_bit17", 32'(nb[0] - b_nb), 32'd15);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_vals", {26'd0, o_ready[0], o_busy[0], o_done[0], o_sclk[0], o_sdata[0], o_scs[0]}, 32'b1000011);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_no_done", 32'(dcnt[0] - b_dcnt), 32'd0);
    run_cmd(0, 4'h6, 16'h9ABC, 1'b1, 32'h00169ABC, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1, "timeout");
  end

endmodule
